// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
//
// Expands one 512-bit SHA-256 block into the 64-word message schedule
// W[0..63]. Sixteen message words are loaded over a valid/ready handshake
// into a 16-entry circular buffer. The schedule is then streamed out one
// word per accepted output handshake. W[16..63] are computed in place, so
// the buffer always holds the 16 most recent schedule words.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   start      begin a new block (honoured only when idle)
//   in_valid   in_data holds a message word
//   in_data    message word, M[0] first
//   in_ready   block accepts a word (high only while loading)
//   out_valid  out_data/out_idx hold W[out_idx]
//   out_ready  consumer accepts the word
//   out_data   schedule word W[t], zero while out_valid is low
//   out_idx    t, the index of the word presented
//   busy       high while loading or streaming
//   done       one-cycle pulse after W[63] is accepted

module sha256_msg_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [5:0]  t;
    logic [31:0] msgBuf [16];

    logic        loading;
    logic        streaming;
    logic        inFire;
    logic        outFire;
    logic        expanding;
    logic [31:0] schedWord;
    logic [3:0]  slotNow;
    logic [3:0]  slotM2;
    logic [3:0]  slotM7;
    logic [3:0]  slotM15;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign loading   = (state == LOAD);
    assign streaming = (state == STREAM);
    assign inFire    = loading && in_valid;
    assign outFire   = streaming && out_ready;
    // Words 0..15 pass straight through; from 16 on, each word is computed.
    assign expanding = (t[5:4] != 2'b00);

    // Circular-buffer slots for W[t-16], W[t-2], W[t-7], W[t-15]; the 4-bit
    // adds wrap modulo 16, which is exactly the (t+k)&15 indexing.
    assign slotNow = t[3:0];
    assign slotM2  = t[3:0] + 4'd14;
    assign slotM7  = t[3:0] + 4'd9;
    assign slotM15 = t[3:0] + 4'd1;

    always_comb begin
        schedWord = sigma1(msgBuf[slotM2]) + msgBuf[slotM7]
                  + sigma0(msgBuf[slotM15]) + msgBuf[slotNow];
    end

    always_comb begin
        out_data = '0;
        if (streaming) begin
            out_data = expanding ? schedWord : msgBuf[slotNow];
        end
    end

    assign in_ready  = loading;
    assign out_valid = streaming;
    assign out_idx   = streaming ? t : '0;
    assign busy      = loading || streaming;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            t     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (inFire) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state <= STREAM;
                            t     <= '0;
                        end
                    end
                end
                STREAM: begin
                    if (outFire) begin
                        // t wraps 63 -> 0, leaving it cleared for the next block.
                        t <= t + 6'd1;
                        if (t == 6'd63) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Buffer storage carries no reset; its contents are only observable
    // after a full reload.
    always_ff @(posedge clk) begin
        if (inFire) begin
            msgBuf[cnt] <= in_data;
        end else if (outFire && expanding) begin
            msgBuf[slotNow] <= schedWord;
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic        busy;
    logic        done;

    sha256_msg_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] msg  [16];
    logic [31:0] wRef [64];
    logic [31:0] obsW [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic computeRef;
        for (int i = 0; i < 16; i++) wRef[i] = msg[i];
        for (int i = 16; i < 64; i++)
            wRef[i] = s1(wRef[i-2]) + wRef[i-7] + s0(wRef[i-15]) + wRef[i-16];
    endtask

    task automatic setAbc;
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        computeRef();
    endtask

    task automatic setZero;
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        computeRef();
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  out_data,       32'd0);
        check({tag, "_out_idx"},   32'(out_idx),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    task automatic doStart;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_busy",     32'(busy),     32'd1);
    endtask

    // Feed the 16 words of msg; optional random in_valid gaps (with junk on
    // in_data) and random start pokes that must be ignored.
    task automatic loadBlock(input bit gaps, input bit pokes);
        int accepted = 0;
        int guard = 0;
        while (accepted < 16 && guard < 200) begin
            check("load_in_ready",  32'(in_ready),  32'd1);
            check("load_out_valid", 32'(out_valid), 32'd0);
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? msg[accepted] : $urandom();
            start    = pokes ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (in_valid) accepted++;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = 32'h0;
        start    = 1'b0;
        check("load_timeout",   32'(accepted),  32'd16);
        check("load_to_stream_in_ready",  32'(in_ready),  32'd0);
        check("load_to_stream_out_valid", 32'(out_valid), 32'd1);
        check("load_to_stream_out_idx",   32'(out_idx),   32'd0);
    endtask

    // Consume the schedule, comparing against wRef. With abortAt >= 0, rst is
    // raised when t reaches that index and the block is abandoned.
    task automatic streamBlock(input bit stalls, input bit pokes, input int abortAt,
                               input bit startInDone);
        int tt = 0;
        int guard = 0;
        while (tt < 64 && guard < 1000) begin
            check("stream_out_valid", 32'(out_valid), 32'd1);
            check("stream_out_idx",   32'(out_idx),   32'(tt));
            check("stream_out_data",  out_data,       wRef[tt]);
            check("stream_done",      32'(done),      32'd0);
            if (tt == abortAt) begin
                rst = 1'b1;
                #1;
                checkIdle("rst_mid_stream");
                tick();
                rst = 1'b0;
                tick();
                checkIdle("after_rst");
                tick();
                check("after_rst_no_done", 32'(done), 32'd0);
                return;
            end
            out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = pokes ? 1'($urandom_range(0, 1)) : 1'b0;
            if (out_ready) obsW[tt] = out_data;
            tick();
            if (out_ready) tt++;
            guard++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        check("stream_timeout",  32'(tt),        32'd64);
        check("end_done",        32'(done),      32'd1);
        check("end_busy",        32'(busy),      32'd0);
        check("end_out_valid",   32'(out_valid), 32'd0);
        check("end_out_data",    out_data,       32'd0);
        check("end_in_ready",    32'(in_ready),  32'd0);
        if (startInDone) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("done_start_in_ready", 32'(in_ready), 32'd1);
            check("done_start_busy",     32'(busy),     32'd1);
            check("done_start_done_low", 32'(done),     32'd0);
        end else begin
            tick();
            check("done_one_cycle",  32'(done), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int c0;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        // Reset state, then idle with in_valid ignored.
        tick();
        tick();
        checkIdle("reset");
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        tick();
        in_valid = 1'b0;
        checkIdle("idle_in_valid_ignored");

        // "abc" block, unstalled; start re-asserted in the done cycle.
        setAbc();
        doStart();
        loadBlock(1'b0, 1'b0);
        streamBlock(1'b0, 1'b0, -1, 1'b1);
        check("abc_W16", obsW[16], 32'h61626380);
        check("abc_W17", obsW[17], 32'h000F0000);
        check("abc_W18", obsW[18], 32'h7DA86405);

        // Already loading: "abc" again with input gaps, output stalls and start pokes.
        loadBlock(1'b1, 1'b1);
        streamBlock(1'b1, 1'b1, -1, 1'b0);

        // All-zero block, best-case timing from start to done.
        setZero();
        c0 = cyc;
        doStart();
        loadBlock(1'b0, 1'b0);
        streamBlock(1'b0, 1'b0, -1, 1'b0);
        check("zero_start_to_done", 32'(cyc - c0 - 1), 32'd81);

        // Reset at t=30 mid-stream, then a fresh "abc" block.
        setAbc();
        doStart();
        loadBlock(1'b0, 1'b0);
        streamBlock(1'b0, 1'b0, 30, 1'b0);
        doStart();
        loadBlock(1'b0, 1'b0);
        streamBlock(1'b0, 1'b0, -1, 1'b0);
        check("abc_rerun_W18", obsW[18], 32'h7DA86405);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
